// File: rtl/paillier_task_driver_pkg.sv
// Shared types and constants for the Paillier task driver: command codes, FSM states,
// error codes and operand slot numbers.
package paillier_drv_pkg;

  typedef enum logic [2:0] {
    CMD_ENC  = 3'b000,
    CMD_DEC  = 3'b001,
    CMD_ADD  = 3'b010,
    CMD_SMUL = 3'b011
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_STREAM  = 2'd2,
    ST_COLLECT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BADCMD  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  localparam logic [1:0] SLOT_OP0 = 2'd0;
  localparam logic [1:0] SLOT_OP1 = 2'd1;
  localparam logic [1:0] SLOT_OP2 = 2'd2;

  function automatic logic is_task_cmd(input logic [2:0] c);
    return (c <= 3'd3);
  endfunction

endpackage

// File: rtl/paillier_task_driver_if.sv
// Task/operand/result bus between the task driver (master) and paillier_top (slave).
interface paillier_task_driver_if #(
  parameter int unsigned K = 128
);
  logic [2:0]   task_cmd;
  logic         task_req;

  logic [K-1:0] enc_r_data, enc_n_data, enc_m_data, enc_g_data;
  logic         enc_r_valid, enc_n_valid, enc_m_valid, enc_g_valid;

  logic [K-1:0] dec_c_data, dec_lambda_data, dec_n_data;
  logic         dec_c_valid, dec_lambda_valid, dec_n_valid;

  logic [K-1:0] homo_add_c1_data, homo_add_c2_data;
  logic         homo_add_c1_valid, homo_add_c2_valid;

  logic [K-1:0] scalar_mul_c1_data, scalar_mul_const_data;
  logic         scalar_mul_c1_valid, scalar_mul_const_valid;

  logic [K-1:0] res_data;
  logic         res_valid;

  modport master (
    output task_cmd, task_req,
    output enc_r_data, enc_n_data, enc_m_data, enc_g_data,
    output enc_r_valid, enc_n_valid, enc_m_valid, enc_g_valid,
    output dec_c_data, dec_lambda_data, dec_n_data,
    output dec_c_valid, dec_lambda_valid, dec_n_valid,
    output homo_add_c1_data, homo_add_c2_data, homo_add_c1_valid, homo_add_c2_valid,
    output scalar_mul_c1_data, scalar_mul_const_data,
    output scalar_mul_c1_valid, scalar_mul_const_valid,
    input  res_data, res_valid
  );

  modport slave (
    input  task_cmd, task_req,
    input  enc_r_data, enc_n_data, enc_m_data, enc_g_data,
    input  enc_r_valid, enc_n_valid, enc_m_valid, enc_g_valid,
    input  dec_c_data, dec_lambda_data, dec_n_data,
    input  dec_c_valid, dec_lambda_valid, dec_n_valid,
    input  homo_add_c1_data, homo_add_c2_data, homo_add_c1_valid, homo_add_c2_valid,
    input  scalar_mul_c1_data, scalar_mul_const_data,
    input  scalar_mul_c1_valid, scalar_mul_const_valid,
    output res_data, res_valid
  );
endinterface

// File: rtl/paillier_word_ram.sv
// N x K word store with one write port and one registered read port.
// Storage is not reset; only the read register clears on reset.
module paillier_word_ram #(
  parameter  int unsigned K  = 128,
  parameter  int unsigned N  = 32,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [K-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [K-1:0]  rdata
);

  logic [K-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a same-address write in this cycle returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/paillier_task_driver.sv
// Host-side initiator for paillier_top: buffers three operands, issues one task, streams the
// operands word-serially and collects the N-word result with done/error/timeout reporting.
module paillier_task_driver
  import paillier_drv_pkg::*;
#(
  parameter  int unsigned K       = 128,
  parameter  int unsigned N       = 32,
  parameter  int unsigned TIMEOUT = 65536,
  localparam int unsigned AW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            host_wr_en,
  input  logic [1:0]      host_wr_sel,
  input  logic [AW-1:0]   host_wr_addr,
  input  logic [K-1:0]    host_wr_data,
  input  logic [AW-1:0]   host_rd_addr,
  output logic [K-1:0]    host_rd_data,
  input  logic            host_start,
  input  logic [2:0]      host_cmd,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [1:0]      err_code,
  paillier_task_driver_if.master bus
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  state_e         state;
  cmd_e           cmd_q;
  err_e           err_q;
  logic [AW-1:0]  rd_idx;
  logic [AW-1:0]  res_cnt;
  logic [TW-1:0]  tcnt;
  logic           stream_valid;
  logic           capture;
  logic           last_word;
  logic           idle_wr;
  logic [K-1:0]   op0_rdata, op1_rdata, op2_rdata;
  logic           sel_enc, sel_dec, sel_add, sel_smul;

  assign idle_wr   = host_wr_en && (state == ST_IDLE);
  assign capture   = bus.res_valid && ((state == ST_STREAM) || (state == ST_COLLECT));
  assign last_word = capture && (res_cnt == AW'(N - 1));

  paillier_word_ram #(.K(K), .N(N)) u_op0 (
    .clk(clk), .rst(rst), .we(idle_wr && (host_wr_sel == SLOT_OP0)),
    .waddr(host_wr_addr), .wdata(host_wr_data), .raddr(rd_idx), .rdata(op0_rdata)
  );

  paillier_word_ram #(.K(K), .N(N)) u_op1 (
    .clk(clk), .rst(rst), .we(idle_wr && (host_wr_sel == SLOT_OP1)),
    .waddr(host_wr_addr), .wdata(host_wr_data), .raddr(rd_idx), .rdata(op1_rdata)
  );

  paillier_word_ram #(.K(K), .N(N)) u_op2 (
    .clk(clk), .rst(rst), .we(idle_wr && (host_wr_sel == SLOT_OP2)),
    .waddr(host_wr_addr), .wdata(host_wr_data), .raddr(rd_idx), .rdata(op2_rdata)
  );

  paillier_word_ram #(.K(K), .N(N)) u_res (
    .clk(clk), .rst(rst), .we(capture),
    .waddr(res_cnt), .wdata(bus.res_data), .raddr(host_rd_addr), .rdata(host_rd_data)
  );

  // stream_valid lags the STREAM state by one cycle to line up with the registered RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_q        <= CMD_ENC;
      err_q        <= ERR_NONE;
      done         <= 1'b0;
      error        <= 1'b0;
      rd_idx       <= '0;
      res_cnt      <= '0;
      tcnt         <= '0;
      stream_valid <= 1'b0;
    end else begin
      done         <= 1'b0;
      error        <= 1'b0;
      stream_valid <= (state == ST_STREAM);
      case (state)
        ST_IDLE: begin
          if (host_start) begin
            if (is_task_cmd(host_cmd)) begin
              cmd_q   <= cmd_e'(host_cmd);
              err_q   <= ERR_NONE;
              rd_idx  <= '0;
              res_cnt <= '0;
              tcnt    <= '0;
              state   <= ST_REQ;
            end else begin
              error <= 1'b1;
              err_q <= ERR_BADCMD;
            end
          end
        end
        ST_REQ: begin
          tcnt  <= tcnt + 1'b1;
          state <= ST_STREAM;
        end
        default: begin
          tcnt <= tcnt + 1'b1;
          if (state == ST_STREAM) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_idx == AW'(N - 1)) state <= ST_COLLECT;
          end
          if (capture) res_cnt <= res_cnt + 1'b1;
          // Completion takes priority over a timeout expiring in the same cycle.
          if (last_word) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (tcnt >= TW'(TIMEOUT - 1)) begin
            error <= 1'b1;
            err_q <= ERR_TIMEOUT;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign err_code = err_q;

  assign sel_enc  = stream_valid && (cmd_q == CMD_ENC);
  assign sel_dec  = stream_valid && (cmd_q == CMD_DEC);
  assign sel_add  = stream_valid && (cmd_q == CMD_ADD);
  assign sel_smul = stream_valid && (cmd_q == CMD_SMUL);

  assign bus.task_req = (state == ST_REQ);
  assign bus.task_cmd = cmd_q;

  assign bus.enc_r_valid = sel_enc;
  assign bus.enc_n_valid = sel_enc;
  assign bus.enc_m_valid = sel_enc;
  assign bus.enc_r_data  = sel_enc ? op0_rdata : '0;
  assign bus.enc_n_data  = sel_enc ? op1_rdata : '0;
  assign bus.enc_m_data  = sel_enc ? op2_rdata : '0;
  assign bus.enc_g_valid = 1'b0;
  assign bus.enc_g_data  = '0;

  assign bus.dec_c_valid      = sel_dec;
  assign bus.dec_lambda_valid = sel_dec;
  assign bus.dec_n_valid      = sel_dec;
  assign bus.dec_c_data       = sel_dec ? op0_rdata : '0;
  assign bus.dec_lambda_data  = sel_dec ? op1_rdata : '0;
  assign bus.dec_n_data       = sel_dec ? op2_rdata : '0;

  assign bus.homo_add_c1_valid = sel_add;
  assign bus.homo_add_c2_valid = sel_add;
  assign bus.homo_add_c1_data  = sel_add ? op0_rdata : '0;
  assign bus.homo_add_c2_data  = sel_add ? op1_rdata : '0;

  assign bus.scalar_mul_c1_valid    = sel_smul;
  assign bus.scalar_mul_const_valid = sel_smul;
  assign bus.scalar_mul_c1_data     = sel_smul ? op0_rdata : '0;
  assign bus.scalar_mul_const_data  = sel_smul ? op1_rdata : '0;

endmodule

// File: tb/tb_paillier_task_driver.sv
// Directed/randomized bench for paillier_task_driver with an in-bench stub responder
// and an operand/result reference model.
module tb_paillier_task_driver;
  import paillier_drv_pkg::*;

  localparam int unsigned K       = 128;
  localparam int unsigned N       = 32;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned AW      = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          host_wr_en;
  logic [1:0]    host_wr_sel;
  logic [AW-1:0] host_wr_addr;
  logic [K-1:0]  host_wr_data;
  logic [AW-1:0] host_rd_addr;
  logic [K-1:0]  host_rd_data;
  logic          host_start;
  logic [2:0]    host_cmd;
  logic          busy, done, error;
  logic [1:0]    err_code;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [K-1:0] op_model  [3][N];
  logic [K-1:0] res_model [N];

  paillier_task_driver_if #(.K(K)) bus_if ();

  paillier_task_driver #(.K(K), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_wr_sel(host_wr_sel), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .host_start(host_start), .host_cmd(host_cmd),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Operand buses flattened: 0..2 ENC r/n/m, 3..5 DEC c/lambda/n, 6..7 ADD c1/c2, 8..9 SMUL c1/const
  logic [9:0]   v_obs;
  logic [K-1:0] d_obs [10];
  assign v_obs = {bus_if.scalar_mul_const_valid, bus_if.scalar_mul_c1_valid,
                  bus_if.homo_add_c2_valid, bus_if.homo_add_c1_valid,
                  bus_if.dec_n_valid, bus_if.dec_lambda_valid, bus_if.dec_c_valid,
                  bus_if.enc_m_valid, bus_if.enc_n_valid, bus_if.enc_r_valid};
  assign d_obs[0] = bus_if.enc_r_data;
  assign d_obs[1] = bus_if.enc_n_data;
  assign d_obs[2] = bus_if.enc_m_data;
  assign d_obs[3] = bus_if.dec_c_data;
  assign d_obs[4] = bus_if.dec_lambda_data;
  assign d_obs[5] = bus_if.dec_n_data;
  assign d_obs[6] = bus_if.homo_add_c1_data;
  assign d_obs[7] = bus_if.homo_add_c2_data;
  assign d_obs[8] = bus_if.scalar_mul_c1_data;
  assign d_obs[9] = bus_if.scalar_mul_const_data;

  function automatic int slot_of(input int unsigned cmd, input int unsigned b);
    case (cmd)
      0: return (b <= 2) ? int'(b) : -1;
      1: return (b >= 3 && b <= 5) ? int'(b) - 3 : -1;
      2: return (b == 6 || b == 7) ? int'(b) - 6 : -1;
      3: return (b == 8 || b == 9) ? int'(b) - 8 : -1;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ops(input bit rnd);
    for (int unsigned s = 0; s < 3; s++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (rnd) op_model[s][i] = {$urandom, $urandom, $urandom, $urandom};
        else     op_model[s][i] = K'(s * 32'h100 + i + (s == 0 ? 1 : 0));
        host_wr_en   = 1'b1;
        host_wr_sel  = 2'(s);
        host_wr_addr = AW'(i);
        host_wr_data = op_model[s][i];
        tick();
      end
    end
    host_wr_en = 1'b0;
  endtask

  // Full task: request, operand stream check, stub results with gaps, stray word, readback.
  task automatic run_task(input int unsigned cmd, input bit inject, input logic [K-1:0] base);
    int unsigned gap;
    int unsigned a;
    int          slot;
    bit          exp_v;
    for (int unsigned i = 0; i < N; i++)
      res_model[i] = (base != '0) ? base + K'(i) : {$urandom, $urandom, $urandom, $urandom};
    host_cmd   = 3'(cmd);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("req_pulse", K'(bus_if.task_req), K'(1));
    chk("req_cmd", K'(bus_if.task_cmd), K'(cmd));
    chk("req_busy", K'(busy), K'(1));
    chk("req_errcode_cleared", K'(err_code), K'(0));
    for (int unsigned k = 1; k <= N + 3; k++) begin
      if (inject && k <= 10) begin
        host_start   = 1'b1;
        host_cmd     = 3'd0;
        host_wr_en   = 1'b1;
        host_wr_sel  = 2'(k % 3);
        host_wr_addr = AW'(k);
        host_wr_data = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        host_start = 1'b0;
        host_wr_en = 1'b0;
      end
      tick();
      chk("no_second_req", K'(bus_if.task_req), K'(0));
      chk("enc_g_valid", K'(bus_if.enc_g_valid), K'(0));
      for (int unsigned b = 0; b < 10; b++) begin
        slot  = slot_of(cmd, b);
        exp_v = (k >= 2) && (k <= N + 1) && (slot >= 0);
        chk($sformatf("valid_b%0d_k%0d", b, k), K'(v_obs[b]), K'(exp_v));
        chk($sformatf("data_b%0d_k%0d", b, k), d_obs[b], exp_v ? op_model[slot][k-2] : '0);
      end
    end
    host_start = 1'b0;
    host_wr_en = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      gap = $urandom_range(3);
      repeat (gap) begin
        tick();
        chk("busy_in_gap", K'(busy), K'(1));
        chk("done_in_gap", K'(done), K'(0));
      end
      bus_if.res_data  = res_model[i];
      bus_if.res_valid = 1'b1;
      tick();
      bus_if.res_valid = 1'b0;
      bus_if.res_data  = '0;
      chk($sformatf("done_w%0d", i), K'(done), K'(i == N - 1));
      chk($sformatf("busy_w%0d", i), K'(busy), K'(i != N - 1));
    end
    bus_if.res_data  = {$urandom, $urandom, $urandom, $urandom};
    bus_if.res_valid = 1'b1;
    tick();
    bus_if.res_valid = 1'b0;
    chk("done_pulse_ends", K'(done), K'(0));
    chk("stray_no_busy", K'(busy), K'(0));
    for (int unsigned j = 0; j < 4; j++) begin
      a = (j == 0) ? 0 : (j == 1) ? 5 : (j == 2) ? N - 1 : $urandom_range(N - 1);
      host_rd_addr = AW'(a);
      tick();
      chk($sformatf("readback_a%0d", a), host_rd_data, res_model[a]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned k;
    bit          seen;
    rst = 1'b1;
    host_wr_en = 1'b0; host_wr_sel = '0; host_wr_addr = '0; host_wr_data = '0;
    host_rd_addr = '0; host_start = 1'b0; host_cmd = '0;
    bus_if.res_data = '0; bus_if.res_valid = 1'b0;
    tick();
    tick();
    chk("rst_busy", K'(busy), K'(0));
    chk("rst_done", K'(done), K'(0));
    chk("rst_error", K'(error), K'(0));
    chk("rst_err_code", K'(err_code), K'(0));
    chk("rst_task_req", K'(bus_if.task_req), K'(0));
    chk("rst_task_cmd", K'(bus_if.task_cmd), K'(0));
    chk("rst_valids", K'(v_obs), K'(0));
    chk("rst_enc_r_data", bus_if.enc_r_data, '0);
    chk("rst_rd_data", host_rd_data, '0);
    rst = 1'b0;
    tick();

    // ENC with patterned operands, stub results 0xA000+i
    write_ops(1'b0);
    run_task(0, 1'b0, K'(32'hA000));

    // DEC with silent stub -> timeout
    host_cmd   = 3'd1;
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("dec_req", K'(bus_if.task_req), K'(1));
    chk("dec_cmd", K'(bus_if.task_cmd), K'(1));
    k = 0;
    seen = 1'b0;
    while (k < TIMEOUT + 200 && !seen) begin
      tick();
      k++;
      if (k == 2) begin
        chk("dec_c_first", bus_if.dec_c_data, op_model[0][0]);
        chk("dec_lambda_first", bus_if.dec_lambda_data, op_model[1][0]);
        chk("dec_n_first", bus_if.dec_n_data, op_model[2][0]);
        chk("dec_enc_quiet", K'(bus_if.enc_r_valid), K'(0));
      end
      if (error) seen = 1'b1;
    end
    chk("timeout_latency", K'(k), K'(TIMEOUT));
    chk("timeout_err_code", K'(err_code), K'(2));
    chk("timeout_busy", K'(busy), K'(0));
    chk("timeout_no_done", K'(done), K'(0));
    tick();
    chk("timeout_pulse_ends", K'(error), K'(0));
    chk("timeout_code_holds", K'(err_code), K'(2));

    // Bad command
    host_cmd   = 3'b101;
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("badcmd_error", K'(error), K'(1));
    chk("badcmd_code", K'(err_code), K'(1));
    chk("badcmd_no_req", K'(bus_if.task_req), K'(0));
    chk("badcmd_busy", K'(busy), K'(0));
    tick();
    chk("badcmd_pulse_ends", K'(error), K'(0));
    chk("badcmd_no_req2", K'(bus_if.task_req), K'(0));
    chk("badcmd_busy2", K'(busy), K'(0));

    // ADD with start/write attempts while busy
    run_task(2, 1'b1, '0);

    // Async reset mid-stream, then a fresh ENC task
    write_ops(1'b1);
    host_cmd   = 3'd0;
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_stream_valid", K'(bus_if.enc_r_valid), K'(1));
    rst = 1'b1;
    #1;
    chk("midrst_valids", K'(v_obs), K'(0));
    chk("midrst_busy", K'(busy), K'(0));
    chk("midrst_task_req", K'(bus_if.task_req), K'(0));
    chk("midrst_enc_r_data", bus_if.enc_r_data, '0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", K'(busy), K'(0));
    run_task(0, 1'b0, '0);

    // SMUL with random results
    run_task(3, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
